// File: rtl/CommandsLocal.sv
// Shared backend and stash command encodings.
package CommandsLocal;

    localparam int unsigned BECMDWidth = 2;
    localparam logic [BECMDWidth-1:0] BECMD_Read    = 2'd0;
    localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = 2'd1;
    localparam logic [BECMDWidth-1:0] BECMD_Update  = 2'd2;
    localparam logic [BECMDWidth-1:0] BECMD_Append  = 2'd3;

    localparam int unsigned STCMDWidth = 2;
    localparam logic [STCMDWidth-1:0] STCMD_StartRead  = 2'd0;
    localparam logic [STCMDWidth-1:0] STCMD_StartWrite = 2'd1;
    localparam logic [STCMDWidth-1:0] STCMD_Append     = 2'd2;

endpackage

// File: rtl/stash_cmd_scheduler_pkg.sv
// Scheduler FSM encodings and launch helpers.
package stash_cmd_scheduler_pkg;

    import CommandsLocal::*;

    localparam int unsigned StateWidth = 2;
    localparam logic [StateWidth-1:0] ST_Idle   = 2'd0;
    localparam logic [StateWidth-1:0] ST_Read   = 2'd1;
    localparam logic [StateWidth-1:0] ST_Write  = 2'd2;
    localparam logic [StateWidth-1:0] ST_Append = 2'd3;

    // Appends skip the read/write path pair and go straight to the stash.
    function automatic logic [StateWidth-1:0] launchState(input logic [BECMDWidth-1:0] cmd);
        return (cmd == BECMD_Append) ? ST_Append : ST_Read;
    endfunction

    function automatic logic [STCMDWidth-1:0] launchCommand(input logic [BECMDWidth-1:0] cmd);
        return (cmd == BECMD_Append) ? STCMD_Append : STCMD_StartRead;
    endfunction

endpackage

// File: rtl/access_interval_timer.sv
// Countdown between path accesses for periodic (timing-protected) mode.
module access_interval_timer #(
    parameter int unsigned IntervalWidth = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Load,
    input  logic [IntervalWidth-1:0] LoadValue,
    output logic                     Expired_c
);

    logic [IntervalWidth-1:0] count;

    // Reload on each path start, otherwise count down and hold at zero.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= LoadValue;
        end else if (count != '0) begin
            count <= count - IntervalWidth'(1);
        end
    end

    assign Expired_c = (count == '0);

endmodule

// File: rtl/stash_cmd_scheduler.sv
// Chooses real or dummy ORAM accesses and sequences the stash commands for each.
module stash_cmd_scheduler
    import CommandsLocal::*;
    import stash_cmd_scheduler_pkg::*;
#(
    parameter int unsigned ORAMU         = 32,
    parameter int unsigned ORAML         = 32,
    parameter int unsigned MaxDummyRun   = 64,
    parameter int unsigned IntervalWidth = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [BECMDWidth-1:0]    ReqBECommand,
    input  logic [ORAMU-1:0]         ReqPAddr,
    input  logic [ORAML-1:0]         ReqCurrentLeaf,
    input  logic [ORAML-1:0]         ReqRemappedLeaf,
    input  logic [ORAML-1:0]         DummyLeaf,
    input  logic                     PeriodicMode,
    input  logic [IntervalWidth-1:0] Interval,
    input  logic                     StashAlmostFull,
    output logic [STCMDWidth-1:0]    StashCommand,
    output logic                     StashCommandValid,
    input  logic                     StashCommandReady,
    output logic [BECMDWidth-1:0]    BECommand,
    output logic [ORAMU-1:0]         PAddr,
    output logic [ORAML-1:0]         CurrentLeaf,
    output logic [ORAML-1:0]         RemappedLeaf,
    output logic                     AccessIsDummy,
    output logic                     AccessSkipsWriteback,
    output logic [31:0]              DummyCount,
    output logic                     ERROR_DummyRun
);

    localparam int unsigned RunWidth = $clog2(MaxDummyRun + 1);

    logic [StateWidth-1:0] state, stateNext;
    logic                  launchEnable;
    logic                  intervalExpired;
    logic                  launchSlot, realGo, dummyGo, startReadAccept, dummyRead;
    logic [RunWidth-1:0]   runCnt, runCntNext;
    logic [STCMDWidth-1:0] cmdNext;
    logic                  validNext, dummyNext, errorNext;
    logic [BECMDWidth-1:0] beNext;
    logic [ORAMU-1:0]      pAddrNext;
    logic [ORAML-1:0]      curLeafNext, remLeafNext;
    logic [31:0]           dummyCountNext;

    access_interval_timer #(
        .IntervalWidth(IntervalWidth)
    ) intervalTimer (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (startReadAccept),
        .LoadValue (Interval),
        .Expired_c (intervalExpired)
    );

    assign ReqReady             = realGo;
    assign AccessSkipsWriteback = 1'b0;

    // Launch decision, next state, next command/fields and counter updates.
    always_comb begin
        stateNext      = state;
        cmdNext        = StashCommand;
        validNext      = StashCommandValid;
        beNext         = BECommand;
        pAddrNext      = PAddr;
        curLeafNext    = CurrentLeaf;
        remLeafNext    = RemappedLeaf;
        dummyNext      = AccessIsDummy;
        dummyCountNext = DummyCount;
        runCntNext     = runCnt;
        errorNext      = ERROR_DummyRun;
        realGo         = 1'b0;
        dummyGo        = 1'b0;

        launchSlot = ~PeriodicMode | intervalExpired;
        if (launchEnable && state == ST_Idle) begin
            // A waiting real request takes the slot unless the stash must drain first.
            realGo  = ReqValid & launchSlot & ~StashAlmostFull;
            dummyGo = (~ReqValid & PeriodicMode & intervalExpired)
                    | (ReqValid & StashAlmostFull & launchSlot);
        end
        startReadAccept = (state == ST_Read) & StashCommandValid & StashCommandReady;
        dummyRead       = startReadAccept & AccessIsDummy;

        case (state)
            ST_Idle: begin
                if (realGo) begin
                    stateNext   = launchState(ReqBECommand);
                    cmdNext     = launchCommand(ReqBECommand);
                    validNext   = 1'b1;
                    beNext      = ReqBECommand;
                    pAddrNext   = ReqPAddr;
                    curLeafNext = ReqCurrentLeaf;
                    remLeafNext = ReqRemappedLeaf;
                    dummyNext   = 1'b0;
                end else if (dummyGo) begin
                    stateNext   = ST_Read;
                    cmdNext     = STCMD_StartRead;
                    validNext   = 1'b1;
                    beNext      = BECMD_Read;
                    pAddrNext   = '0;
                    curLeafNext = DummyLeaf;
                    remLeafNext = DummyLeaf;
                    dummyNext   = 1'b1;
                end
            end
            ST_Read: begin
                if (StashCommandReady) begin
                    stateNext = ST_Write;
                    cmdNext   = STCMD_StartWrite;
                end
            end
            ST_Write, ST_Append: begin
                if (StashCommandReady) begin
                    stateNext = ST_Idle;
                    validNext = 1'b0;
                end
            end
            default: begin
                stateNext = ST_Idle;
                validNext = 1'b0;
            end
        endcase

        // Dummy statistics: total count wraps, run length saturates and latches the error.
        if (dummyRead) begin
            dummyCountNext = DummyCount + 32'd1;
        end
        if (realGo) begin
            runCntNext = '0;
        end else if (dummyRead && runCnt < RunWidth'(MaxDummyRun)) begin
            runCntNext = runCnt + RunWidth'(1);
        end
        if (runCntNext == RunWidth'(MaxDummyRun)) begin
            errorNext = 1'b1;
        end
    end

    // State, registered outputs and counters; launches are blocked until the first clock out of reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state             <= ST_Idle;
            launchEnable      <= 1'b0;
            StashCommand      <= STCMD_StartRead;
            StashCommandValid <= 1'b0;
            BECommand         <= '0;
            PAddr             <= '0;
            CurrentLeaf       <= '0;
            RemappedLeaf      <= '0;
            AccessIsDummy     <= 1'b0;
            DummyCount        <= '0;
            runCnt            <= '0;
            ERROR_DummyRun    <= 1'b0;
        end else begin
            state             <= stateNext;
            launchEnable      <= 1'b1;
            StashCommand      <= cmdNext;
            StashCommandValid <= validNext;
            BECommand         <= beNext;
            PAddr             <= pAddrNext;
            CurrentLeaf       <= curLeafNext;
            RemappedLeaf      <= remLeafNext;
            AccessIsDummy     <= dummyNext;
            DummyCount        <= dummyCountNext;
            runCnt            <= runCntNext;
            ERROR_DummyRun    <= errorNext;
        end
    end

endmodule

// File: tb/tb_stash_cmd_scheduler.sv
// Scoreboard bench for stash_cmd_scheduler: directed accesses, dummy insertion and error/reset behaviour.
module tb_stash_cmd_scheduler;

    import CommandsLocal::*;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [1:0]  be;
        logic [31:0] addr;
        logic [31:0] cur;
        logic [31:0] rem;
        logic        dummy;
    } exp_t;

    logic        Clock, Reset;
    logic        ReqValid, ReqReady;
    logic [1:0]  ReqBECommand;
    logic [31:0] ReqPAddr, ReqCurrentLeaf, ReqRemappedLeaf, DummyLeaf;
    logic        PeriodicMode;
    logic [15:0] Interval;
    logic        StashAlmostFull;
    logic [1:0]  StashCommand;
    logic        StashCommandValid, StashCommandReady;
    logic [1:0]  BECommand;
    logic [31:0] PAddr, CurrentLeaf, RemappedLeaf;
    logic        AccessIsDummy, AccessSkipsWriteback;
    logic [31:0] DummyCount;
    logic        ERROR_DummyRun;

    exp_t expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;
    int   cyc      = 0;

    stash_cmd_scheduler #(
        .ORAMU(32), .ORAML(32), .MaxDummyRun(4), .IntervalWidth(16)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqBECommand(ReqBECommand),
        .ReqPAddr(ReqPAddr), .ReqCurrentLeaf(ReqCurrentLeaf), .ReqRemappedLeaf(ReqRemappedLeaf),
        .DummyLeaf(DummyLeaf), .PeriodicMode(PeriodicMode), .Interval(Interval),
        .StashAlmostFull(StashAlmostFull), .StashCommand(StashCommand),
        .StashCommandValid(StashCommandValid), .StashCommandReady(StashCommandReady),
        .BECommand(BECommand), .PAddr(PAddr), .CurrentLeaf(CurrentLeaf), .RemappedLeaf(RemappedLeaf),
        .AccessIsDummy(AccessIsDummy), .AccessSkipsWriteback(AccessSkipsWriteback),
        .DummyCount(DummyCount), .ERROR_DummyRun(ERROR_DummyRun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        totalCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Accepted stash commands are popped and compared in order.
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Reset && StashCommandValid && StashCommandReady) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_cmd: got cmd %0d addr %h with nothing expected", StashCommand, PAddr);
            end else begin
                e = expQ.pop_front();
                check("stash_cmd",
                      128'({StashCommand, BECommand, PAddr, CurrentLeaf, RemappedLeaf, AccessIsDummy}),
                      128'(e));
            end
        end
    end

    task automatic expectAccess(input logic [1:0] be, input logic [31:0] addr, input logic [31:0] cur,
                                input logic [31:0] rem, input logic dummy);
        exp_t e;
        e.be = be; e.addr = addr; e.cur = cur; e.rem = rem; e.dummy = dummy;
        if (be == BECMD_Append) begin
            e.cmd = STCMD_Append;
            expQ.push_back(e);
        end else begin
            e.cmd = STCMD_StartRead;
            expQ.push_back(e);
            e.cmd = STCMD_StartWrite;
            expQ.push_back(e);
        end
    endtask

    task automatic waitReqReady(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (ReqReady) begin
                lat = i;
                break;
            end
        end
        check("req_ready_seen", 128'(lat >= 0), 128'(1));
        @(posedge Clock); #1;
        ReqValid = 1'b0;
    endtask

    task automatic issueReq(input logic [1:0] be, input logic [31:0] addr, input logic [31:0] cur,
                            input logic [31:0] rem, output int lat);
        @(posedge Clock); #1;
        ReqValid = 1'b1; ReqBECommand = be; ReqPAddr = addr;
        ReqCurrentLeaf = cur; ReqRemappedLeaf = rem;
        expectAccess(be, addr, cur, rem, 1'b0);
        waitReqReady(lat);
    endtask

    task automatic waitDone(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (expQ.size() == 0 && !StashCommandValid) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 128'(done), 128'(1));
    endtask

    task automatic waitCmd(input logic [1:0] cmd, input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge Clock);
            if (StashCommandValid && StashCommand == cmd) begin
                found = 1'b1;
                break;
            end
        end
        check("cmd_seen", 128'(found), 128'(1));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  lat, dummies, lastCyc;
        bit  sawReady, found;

        Reset = 1'b0; ReqValid = 1'b1; ReqBECommand = BECMD_Read; ReqPAddr = 32'h0;
        ReqCurrentLeaf = 32'h0; ReqRemappedLeaf = 32'h0; DummyLeaf = 32'h0;
        PeriodicMode = 1'b0; Interval = 16'd0; StashAlmostFull = 1'b0; StashCommandReady = 1'b1;

        // Reset state, with a request already waiting.
        repeat (3) @(negedge Clock);
        check("reset_state", 128'({ReqReady, StashCommandValid, StashCommand, BECommand, PAddr,
                                   CurrentLeaf, RemappedLeaf, AccessIsDummy, ERROR_DummyRun}), 128'(0));
        check("reset_dummy_count", 128'(DummyCount), 128'(0));
        check("skips_writeback", 128'(AccessSkipsWriteback), 128'(0));
        #2 Reset = 1'b1;
        #1 check("no_launch_before_clock", 128'(ReqReady), 128'(0));
        ReqValid = 1'b0;
        repeat (2) @(posedge Clock);

        // Basic read: ReqReady cycle 0, StartRead 1, StartWrite 2, idle 3.
        issueReq(BECMD_Read, 32'h10, 32'h5, 32'h6, lat);
        check("read_ready_cycle", 128'(lat), 128'(0));
        @(negedge Clock);
        check("read_cycle1", 128'({StashCommandValid, StashCommand}), 128'({1'b1, STCMD_StartRead}));
        @(negedge Clock);
        check("read_cycle2", 128'({StashCommandValid, StashCommand}), 128'({1'b1, STCMD_StartWrite}));
        @(negedge Clock);
        check("read_cycle3", 128'({StashCommandValid, ReqReady}), 128'(0));
        waitDone("done_read");

        // Other command types with the stash always ready.
        issueReq(BECMD_ReadRmv, 32'h20, 32'h21, 32'h22, lat);
        waitDone("done_readrmv");
        issueReq(BECMD_Update, 32'hABCD, 32'h1234, 32'h4321, lat);
        waitDone("done_update");
        issueReq(BECMD_Append, 32'h30, 32'h31, 32'h32, lat);
        waitDone("done_append");

        // Append held off by the stash for 5 cycles.
        StashCommandReady = 1'b0;
        issueReq(BECMD_Append, 32'h55, 32'h7, 32'h9, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("append_hold", 128'({StashCommandValid, StashCommand, BECommand, PAddr, CurrentLeaf, RemappedLeaf}),
                  128'({1'b1, STCMD_Append, BECMD_Append, 32'h55, 32'h7, 32'h9}));
        end
        @(posedge Clock); #1;
        StashCommandReady = 1'b1;
        waitDone("done_append_hold");

        // Update pending while the stash is almost full: three dummies first.
        @(posedge Clock); #1;
        StashAlmostFull = 1'b1; DummyLeaf = 32'h3A;
        ReqValid = 1'b1; ReqBECommand = BECMD_Update; ReqPAddr = 32'h77;
        ReqCurrentLeaf = 32'h11; ReqRemappedLeaf = 32'h12;
        for (int k = 0; k < 3; k++) expectAccess(BECMD_Read, 32'h0, 32'h3A, 32'h3A, 1'b1);
        expectAccess(BECMD_Update, 32'h77, 32'h11, 32'h12, 1'b0);
        sawReady = 1'b0; dummies = 0;
        for (int i = 0; i < 40 && dummies < 3; i++) begin
            @(negedge Clock);
            if (ReqReady) sawReady = 1'b1;
            if (StashCommandValid && StashCommandReady && StashCommand == STCMD_StartWrite && AccessIsDummy)
                dummies++;
        end
        check("dummies_before_real", 128'(dummies), 128'(3));
        check("ready_low_while_full", 128'(sawReady), 128'(0));
        @(posedge Clock); #1;
        StashAlmostFull = 1'b0;
        waitReqReady(lat);
        check("real_after_drain_cycle", 128'(lat), 128'(0));
        waitDone("done_almost_full");
        check("dummy_count_3", 128'({ERROR_DummyRun, DummyCount}), 128'({1'b0, 32'd3}));

        // Periodic mode, no requests: one dummy every 22 cycles, leaf captured at launch.
        @(posedge Clock); #1;
        Interval = 16'd20; DummyLeaf = 32'h1000;
        expectAccess(BECMD_Read, 32'h0, 32'h1000, 32'h1000, 1'b1);
        PeriodicMode = 1'b1;
        lastCyc = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge Clock); #1;
                DummyLeaf = 32'h1000 + 32'(k);
                expectAccess(BECMD_Read, 32'h0, 32'h1000 + 32'(k), 32'h1000 + 32'(k), 1'b1);
            end
            waitCmd(STCMD_StartRead, 40, found);
            if (k > 0) check("dummy_period", 128'(cyc - lastCyc), 128'(22));
            lastCyc = cyc;
            @(posedge Clock); #1;
            DummyLeaf = 32'hDEAD_0000;
        end
        PeriodicMode = 1'b0;
        waitDone("done_periodic");
        check("periodic_count_err", 128'({ERROR_DummyRun, DummyCount}), 128'({1'b1, 32'd7}));

        // Fresh reset, then a stuck almost-full stash drives the dummy-run error.
        @(posedge Clock); #1;
        Reset = 1'b0; Interval = 16'd0;
        @(negedge Clock);
        check("reset_clears_err", 128'({ERROR_DummyRun, DummyCount}), 128'(0));
        #2 Reset = 1'b1;
        @(posedge Clock); #1;
        DummyLeaf = 32'h2222; StashAlmostFull = 1'b1;
        ReqValid = 1'b1; ReqBECommand = BECMD_Update; ReqPAddr = 32'h99;
        for (int k = 0; k < 6; k++) expectAccess(BECMD_Read, 32'h0, 32'h2222, 32'h2222, 1'b1);
        for (int k = 0; k < 6; k++) begin
            waitCmd(STCMD_StartWrite, 10, found);
            check("run_err_count", 128'({ERROR_DummyRun, DummyCount}),
                  128'({(k >= 3) ? 1'b1 : 1'b0, 32'(k + 1)}));
        end
        // Asynchronous reset in the middle of a StartWrite.
        #2 Reset = 1'b0;
        ReqValid = 1'b0; StashAlmostFull = 1'b0;
        #1 check("async_reset_mid_write",
                 128'({StashCommandValid, StashCommand, ERROR_DummyRun, DummyCount, ReqReady, PAddr}), 128'(0));
        check("queue_drained", 128'(expQ.size()), 128'(0));
        @(posedge Clock); #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
